// File: rtl/oifs_rx_interface.sv
// -----------------------------------------------------------------------------
// oifs_rx_interface
// Receive side of the opto-isolated fast-serial link. Samples FSDO on the
// shared bit tick and deserialises frames of one start bit (0), DATA_W data
// bits (LSB first) and one channel/source bit. Each completed frame is
// presented on a one-entry valid/ready output register.
//
// Optional feature: define OIFS_RX_OVERRUN_EN to add the sticky o_overrun
// flag and its i_overrun_clr clear input. Without it, frames that arrive
// while the output register is still full are dropped silently.
// -----------------------------------------------------------------------------
module oifs_rx_interface #(
    parameter int DATA_W = 8,
    parameter int DFF_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_tick,
    input  logic              i_fsdo,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_channel,
    input  logic              i_ready,
`ifdef OIFS_RX_OVERRUN_EN
    output logic              o_overrun,
    input  logic              i_overrun_clr,
`endif
    output logic              o_busy
);

    // Counter only has to reach DATA_W-1; keep at least one bit.
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        CHAN = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [DATA_W-1:0]  shift_r;
    logic [DATA_W-1:0]  shift_nx_s;
    logic [DFF_W-1:0]   sync_r;
    logic               fsdo_s;
    logic               frame_done_s;
    logic               accept_s;

    // Metastability synchroniser for the asynchronous opto output (no reset).
    always_ff @(posedge i_clk) begin
        sync_r <= {sync_r[DFF_W-2:0], i_fsdo};
    end

    assign fsdo_s       = sync_r[DFF_W-1];
    assign frame_done_s = i_tick & (state_r == CHAN);
    assign accept_s     = ~o_valid | i_ready;
    assign o_busy       = (state_r != IDLE);

    // Frame state, bit counter and shift register; they only move on ticks.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {DATA_W{1'b1}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            shift_r <= shift_nx_s;
        end
    end

    // Next-state logic: start detect, LSB-first shift, channel bit.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        shift_nx_s = shift_r;
        if (i_tick) begin
            case (state_r)
                IDLE: begin
                    // Leading marker/idle ones are skipped; a 0 is the start.
                    if (!fsdo_s) begin
                        state_nx_s = DATA;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                DATA: begin
                    shift_nx_s = {fsdo_s, shift_r[DATA_W-1:1]};
                    if (cnt_r == CNT_LAST) begin
                        state_nx_s = CHAN;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nx_s   = cnt_r + CNT_W'(1);
                    end
                end
                CHAN: begin
                    // Channel bit is consumed by the output register this tick.
                    state_nx_s = IDLE;
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // One-entry output register: load on completion if empty or draining.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_valid   <= 1'b0;
            o_data    <= {DATA_W{1'b0}};
            o_channel <= 1'b0;
        end else if (frame_done_s && accept_s) begin
            o_valid   <= 1'b1;
            o_data    <= shift_r;
            o_channel <= fsdo_s;
        end else if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
        end else begin
            o_valid   <= o_valid;
        end
    end

`ifdef OIFS_RX_OVERRUN_EN
    // Sticky overrun flag: set on a dropped frame, set beats clear.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_overrun <= 1'b0;
        end else if (frame_done_s && !accept_s) begin
            o_overrun <= 1'b1;
        end else if (i_overrun_clr) begin
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= o_overrun;
        end
    end
`endif

endmodule

// File: tb/tb_oifs_rx_interface.sv
// -----------------------------------------------------------------------------
// tb_oifs_rx_interface
// Directed bench with a scoreboard queue: expected words are pushed when a
// frame is driven and popped whenever the DUT hands a word over.
// Honours OIFS_RX_OVERRUN_EN for the overrun checks.
// -----------------------------------------------------------------------------
module tb_oifs_rx_interface;

    localparam int DATA_W = 8;
    localparam int DFF_W  = 2;

    logic              i_clk = 1'b0;
    logic              i_arst;
    logic              i_tick;
    logic              i_fsdo;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_channel;
    logic              i_ready;
    logic              o_busy;
`ifdef OIFS_RX_OVERRUN_EN
    logic              o_overrun;
    logic              i_overrun_clr;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [DATA_W:0] exp_q[$];   // {channel, data}

    oifs_rx_interface #(.DATA_W(DATA_W), .DFF_W(DFF_W)) dut (
        .i_clk         (i_clk),
        .i_arst        (i_arst),
        .i_tick        (i_tick),
        .i_fsdo        (i_fsdo),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_channel     (o_channel),
        .i_ready       (i_ready),
`ifdef OIFS_RX_OVERRUN_EN
        .o_overrun     (o_overrun),
        .i_overrun_clr (i_overrun_clr),
`endif
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake must deliver the oldest expected word.
    always @(negedge i_clk) begin
        if (!i_arst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word_valid", {31'd0, o_valid}, 32'd0);
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                check("word_data", {24'd0, o_data}, {24'd0, e[DATA_W-1:0]});
                check("word_channel", {31'd0, o_channel}, {31'd0, e[DATA_W]});
            end
        end
    end

    // One bit period: settle fsdo through the synchroniser, then tick once.
    // glitch drives the inverted value first to prove only tick-time matters.
    task automatic tick_bit(input logic b, input logic rdy_with_tick, input logic glitch);
        if (glitch) begin
            i_fsdo = ~b;
            repeat (2) @(posedge i_clk);
            #1;
        end
        i_fsdo = b;
        repeat (3) @(posedge i_clk);
        #1;
        i_tick = 1'b1;
        if (rdy_with_tick) i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic ch,
                              input logic expect_accept, input logic rdy_at_chan,
                              input logic glitch);
        if (expect_accept) exp_q.push_back({ch, d});
        tick_bit(1'b0, 1'b0, glitch);
        for (int i = 0; i < DATA_W; i++) tick_bit(d[i], 1'b0, glitch);
        tick_bit(ch, rdy_at_chan, glitch);
    endtask

    initial begin
        i_arst = 1'b1;
        i_tick = 1'b0;
        i_fsdo = 1'b1;
        i_ready = 1'b1;
`ifdef OIFS_RX_OVERRUN_EN
        i_overrun_clr = 1'b0;
`endif
        repeat (4) @(posedge i_clk);
        #1;
        // Reset state
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_channel", {31'd0, o_channel}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
`ifdef OIFS_RX_OVERRUN_EN
        check("rst_overrun", {31'd0, o_overrun}, 32'd0);
`endif
        i_arst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;

        // 1: marker, then 0xA5 channel 1 with busy tracking
        tick_bit(1'b1, 1'b0, 1'b0);
        check("t1_busy_marker", {31'd0, o_busy}, 32'd0);
        exp_q.push_back({1'b1, 8'hA5});
        tick_bit(1'b0, 1'b0, 1'b0);
        check("t1_busy_start", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < DATA_W; i++) begin
            logic [7:0] v;
            v = 8'hA5;
            tick_bit(v[i], 1'b0, 1'b0);
            check("t1_busy_data", {31'd0, o_busy}, 32'd1);
        end
        tick_bit(1'b1, 1'b0, 1'b0);
        check("t1_busy_after_chan", {31'd0, o_busy}, 32'd0);
        check("t1_valid", {31'd0, o_valid}, 32'd1);
        check("t1_data", {24'd0, o_data}, 32'hA5);
        @(posedge i_clk);
        #1;
        check("t1_valid_pulse_end", {31'd0, o_valid}, 32'd0);

        // 2: back-to-back frames, second start on the tick after CHAN
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        tick_bit(1'b0, 1'b0, 1'b0);
        check("t2_back_to_back_start", {31'd0, o_busy}, 32'd1);
        exp_q.push_back({1'b1, 8'hFF});
        for (int i = 0; i < DATA_W; i++) tick_bit(1'b1, 1'b0, 1'b0);
        tick_bit(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        check("t2_queue_drained", exp_q.size(), 32'd0);

        // 3: consumer stalled; second frame is dropped
        i_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_valid_first", {31'd0, o_valid}, 32'd1);
        check("t3_data_first", {24'd0, o_data}, 32'h11);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_valid_held", {31'd0, o_valid}, 32'd1);
        check("t3_data_held", {24'd0, o_data}, 32'h11);
        check("t3_channel_held", {31'd0, o_channel}, 32'd0);
`ifdef OIFS_RX_OVERRUN_EN
        check("t3_overrun_set", {31'd0, o_overrun}, 32'd1);
        i_overrun_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_overrun_clr = 1'b0;
        check("t3_overrun_clr", {31'd0, o_overrun}, 32'd0);
`endif

        // 4: handshake in the same cycle as completion of 0x22
        send_frame(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_valid", {31'd0, o_valid}, 32'd1);
        check("t4_data", {24'd0, o_data}, 32'h22);
        check("t4_channel", {31'd0, o_channel}, 32'd1);
`ifdef OIFS_RX_OVERRUN_EN
        check("t4_no_overrun", {31'd0, o_overrun}, 32'd0);
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check("t4_queue_drained", exp_q.size(), 32'd0);

        // 5: reset after 4 data bits, then a clean 0x5A frame
        tick_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick_bit(1'b1, 1'b0, 1'b0);
        check("t5_busy_before_rst", {31'd0, o_busy}, 32'd1);
        i_arst = 1'b1;
        #1;
        check("t5_rst_busy", {31'd0, o_busy}, 32'd0);
        check("t5_rst_valid", {31'd0, o_valid}, 32'd0);
        check("t5_rst_data", {24'd0, o_data}, 32'd0);
        @(posedge i_clk);
        #1;
        i_arst = 1'b0;
        tick_bit(1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_data", {24'd0, o_data}, 32'h5A);

        // 6: line low without ticks, then glitches between ticks
        i_fsdo = 1'b0;
        repeat (100) @(posedge i_clk);
        #1;
        check("t6_no_tick_idle", {31'd0, o_busy}, 32'd0);
        tick_bit(1'b1, 1'b0, 1'b1);
        check("t6_glitch_ignored", {31'd0, o_busy}, 32'd0);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t6_glitch_frame", {24'd0, o_data}, 32'h96);

        // Drain remaining expectations with a bounded wait
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge i_clk);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
